reg_access_ctrl: RTL and testbench

Request sequencer that sits directly upstream of the single-port `registers` file and owns its `en` / `r_or_w` / `reg_addr` / `in` controls. It accepts operand-read-pair and write requests over a valid/ready handshake and serialises them onto the single register-file port. For read requests it captures the two operands on consecutive cycles and returns them together over a valid/ready response channel.

---
 rtl/reg_access_ctrl_if.sv | 38 +++
 rtl/reg_access_ctrl.sv | 107 ++++++++++
 tb/tb_reg_access_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_access_ctrl_if.sv
// Request/response and register-file port bundle for reg_access_ctrl.
// master: requester + register file side; slave: the controller.
interface reg_access_ctrl_if #(
  parameter int WIDTH         = 16,
  parameter int REG_ADDR_BITS = 16
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_wr;
  logic [REG_ADDR_BITS-1:0] req_addr_a;
  logic [REG_ADDR_BITS-1:0] req_addr_b;
  logic [WIDTH-1:0]         req_data;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_a;
  logic [WIDTH-1:0]         rsp_b;
  logic                     rf_en;
  logic                     rf_r_or_w;
  logic [REG_ADDR_BITS-1:0] rf_addr;
  logic [WIDTH-1:0]         rf_wdata;
  logic [WIDTH-1:0]         rf_rdata;

  modport master (
    output req_valid, req_wr, req_addr_a,
    output req_addr_b, req_data, rsp_ready,
    output rf_rdata,
    input  req_ready, rsp_valid, rsp_a, rsp_b,
    input  rf_en, rf_r_or_w, rf_addr, rf_wdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr_a,
    input  req_addr_b, req_data, rsp_ready,
    input  rf_rdata,
    output req_ready, rsp_valid, rsp_a, rsp_b,
    output rf_en, rf_r_or_w, rf_addr, rf_wdata
  );
endinterface

// File: rtl/reg_access_ctrl.sv
// Serialises read-pair / write requests onto a single-port register file.
// Ports: clk, rst (async, active-high), bus (reg_access_ctrl_if.slave).
module reg_access_ctrl #(
  parameter int WIDTH         = 16,
  parameter int REG_ADDR_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  reg_access_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    RESP,
    WR
  } state_t;

  state_t                   state_q, state_d;
  logic [REG_ADDR_BITS-1:0] addr_a_q, addr_a_d;
  logic [REG_ADDR_BITS-1:0] addr_b_q, addr_b_d;
  logic [WIDTH-1:0]         data_q, data_d;
  logic [WIDTH-1:0]         rsp_a_q, rsp_a_d;
  logic [WIDTH-1:0]         rsp_b_q, rsp_b_d;

  always_comb begin
    state_d  = state_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    data_d   = data_q;
    rsp_a_d  = rsp_a_q;
    rsp_b_d  = rsp_b_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_a_d = bus.req_addr_a;
          addr_b_d = bus.req_addr_b;
          data_d   = bus.req_data;
          state_d  = bus.req_wr ? WR : RD_A;
        end
      end
      RD_A: begin
        rsp_a_d = bus.rf_rdata;
        state_d = RD_B;
      end
      RD_B: begin
        rsp_b_d = bus.rf_rdata;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      WR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_a_q <= '0;
      addr_b_q <= '0;
      data_q   <= '0;
      rsp_a_q  <= '0;
      rsp_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      data_q   <= data_d;
      rsp_a_q  <= rsp_a_d;
      rsp_b_q  <= rsp_b_d;
    end
  end

  // Register-file controls come only from state and latched request,
  // so addr/wdata hold steady for the whole level-sensitive write.
  always_comb begin
    bus.rf_en     = 1'b0;
    bus.rf_r_or_w = 1'b0;
    bus.rf_addr   = '0;
    bus.rf_wdata  = '0;
    unique case (1'b1)
      (state_q == RD_A): begin
        bus.rf_en   = 1'b1;
        bus.rf_addr = addr_a_q;
      end
      (state_q == RD_B): begin
        bus.rf_en   = 1'b1;
        bus.rf_addr = addr_b_q;
      end
      (state_q == WR): begin
        bus.rf_en     = 1'b1;
        bus.rf_r_or_w = 1'b1;
        bus.rf_addr   = addr_a_q;
        bus.rf_wdata  = data_q;
      end
      default: ;
    endcase
  end

  // Held low during reset so no request is taken while rst is up.
  assign bus.req_ready = ~rst & (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_a     = rsp_a_q;
  assign bus.rsp_b     = rsp_b_q;
endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a behavioural register file.
// Ports: none (top-level testbench).
module tb_reg_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  reg_access_ctrl_if #(.WIDTH(16), .REG_ADDR_BITS(16)) b ();

  reg_access_ctrl #(.WIDTH(16), .REG_ADDR_BITS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [65536];
  assign b.rf_rdata = mem[b.rf_addr];
  always @(posedge clk)
    if (b.rf_en && b.rf_r_or_w) mem[b.rf_addr] <= b.rf_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [15:0] a,
                       input logic [15:0] bb, input logic [15:0] d);
    b.req_valid  = 1'b1;
    b.req_wr     = wr;
    b.req_addr_a = a;
    b.req_addr_b = bb;
    b.req_data   = d;
    tick();
    b.req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({b.req_ready, b.rsp_valid, b.rf_en, b.rf_r_or_w} !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_ctl got %b want 0000",
               {b.req_ready, b.rsp_valid, b.rf_en, b.rf_r_or_w});
    end
    n_cmp++;
    if ({b.rsp_a, b.rsp_b, b.rf_addr, b.rf_wdata} !== 64'h0) begin
      n_bad++;
      $display("FAIL rst_data got %h want 0",
               {b.rsp_a, b.rsp_b, b.rf_addr, b.rf_wdata});
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({b.req_ready, b.rsp_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL rst_release got %b want 10",
               {b.req_ready, b.rsp_valid});
    end
  endtask

  task automatic test_write_read();
    issue(1'b1, 16'd3, 16'd0, 16'hBEEF);
    n_cmp++;
    if ({b.rf_en, b.rf_r_or_w, b.req_ready} !== 3'b110 ||
        b.rf_addr !== 16'd3 || b.rf_wdata !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL wr1 got en/rw/rdy=%b a=%h d=%h want 110 3 beef",
               {b.rf_en, b.rf_r_or_w, b.req_ready}, b.rf_addr, b.rf_wdata);
    end
    tick();
    n_cmp++;
    if ({b.rf_en, b.req_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL wr1_end got en/rdy=%b want 01", {b.rf_en, b.req_ready});
    end
    issue(1'b1, 16'd7, 16'd0, 16'h1234);
    n_cmp++;
    if ({b.rf_en, b.rf_r_or_w} !== 2'b11 || b.rf_addr !== 16'd7 ||
        b.rf_wdata !== 16'h1234) begin
      n_bad++;
      $display("FAIL wr2 got en/rw=%b a=%h d=%h want 11 7 1234",
               {b.rf_en, b.rf_r_or_w}, b.rf_addr, b.rf_wdata);
    end
    tick();
    n_cmp++;
    if (b.rf_en !== 1'b0) begin
      n_bad++;
      $display("FAIL wr2_end got en=%b want 0", b.rf_en);
    end
    issue(1'b0, 16'd3, 16'd7, 16'h0);
    n_cmp++;
    if ({b.rf_en, b.rf_r_or_w, b.rsp_valid} !== 3'b100 ||
        b.rf_addr !== 16'd3) begin
      n_bad++;
      $display("FAIL rd_a got en/rw/v=%b a=%h want 100 3",
               {b.rf_en, b.rf_r_or_w, b.rsp_valid}, b.rf_addr);
    end
    tick();
    n_cmp++;
    if ({b.rf_en, b.rsp_valid} !== 2'b10 || b.rf_addr !== 16'd7) begin
      n_bad++;
      $display("FAIL rd_b got en/v=%b a=%h want 10 7",
               {b.rf_en, b.rsp_valid}, b.rf_addr);
    end
    tick();
    n_cmp++;
    if (b.rsp_valid !== 1'b1 || b.rsp_a !== 16'hBEEF ||
        b.rsp_b !== 16'h1234 || b.rf_en !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_rsp got v=%b a=%h b=%h en=%b want 1 beef 1234 0",
               b.rsp_valid, b.rsp_a, b.rsp_b, b.rf_en);
    end
    tick();
    n_cmp++;
    if ({b.rsp_valid, b.req_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL rd_done got v/rdy=%b want 01",
               {b.rsp_valid, b.req_ready});
    end
  endtask

  task automatic test_backpressure();
    b.rsp_ready = 1'b0;
    issue(1'b0, 16'd7, 16'd3, 16'h0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({b.rsp_valid, b.req_ready, b.rf_en} !== 3'b100 ||
          b.rsp_a !== 16'h1234 || b.rsp_b !== 16'hBEEF) begin
        n_bad++;
        $display("FAIL bp_hold%0d got v/rdy/en=%b a=%h b=%h want 100 1234 beef",
                 i, {b.rsp_valid, b.req_ready, b.rf_en}, b.rsp_a, b.rsp_b);
      end
      tick();
    end
    b.rsp_ready = 1'b1;
    tick();
    n_cmp++;
    if ({b.rsp_valid, b.req_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_release got v/rdy=%b want 01",
               {b.rsp_valid, b.req_ready});
    end
  endtask

  task automatic test_same_addr();
    int rd_cycles;
    issue(1'b1, 16'd9, 16'd0, 16'h00A5);
    tick();
    rd_cycles = 0;
    issue(1'b0, 16'd9, 16'd9, 16'h0);
    for (int i = 0; i < 3; i++) begin
      if (b.rf_en === 1'b1 && b.rf_r_or_w === 1'b0 &&
          b.rf_addr === 16'd9) rd_cycles++;
      if (i < 2) tick();
    end
    n_cmp++;
    if (rd_cycles !== 2) begin
      n_bad++;
      $display("FAIL same_rdcyc got %0d want 2", rd_cycles);
    end
    n_cmp++;
    if (b.rsp_valid !== 1'b1 || b.rsp_a !== 16'h00A5 ||
        b.rsp_b !== 16'h00A5) begin
      n_bad++;
      $display("FAIL same_rsp got v=%b a=%h b=%h want 1 00a5 00a5",
               b.rsp_valid, b.rsp_a, b.rsp_b);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    b.req_valid  = 1'b1;
    b.req_wr     = 1'b1;
    b.req_addr_a = 16'd2;
    b.req_addr_b = 16'd0;
    b.req_data   = 16'h0F0F;
    tick();
    b.req_wr     = 1'b0;
    b.req_addr_a = 16'd2;
    b.req_addr_b = 16'd0;
    b.req_data   = 16'hFFFF;
    n_cmp++;
    if ({b.rf_en, b.rf_r_or_w} !== 2'b11 || b.rf_addr !== 16'd2 ||
        b.rf_wdata !== 16'h0F0F) begin
      n_bad++;
      $display("FAIL b2b_wr got en/rw=%b a=%h d=%h want 11 2 0f0f",
               {b.rf_en, b.rf_r_or_w}, b.rf_addr, b.rf_wdata);
    end
    tick();
    n_cmp++;
    if ({b.req_ready, b.rf_en} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b_idle got rdy/en=%b want 10", {b.req_ready, b.rf_en});
    end
    tick();
    b.req_valid = 1'b0;
    n_cmp++;
    if ({b.rf_en, b.rf_r_or_w} !== 2'b10 || b.rf_addr !== 16'd2) begin
      n_bad++;
      $display("FAIL b2b_rda got en/rw=%b a=%h want 10 2",
               {b.rf_en, b.rf_r_or_w}, b.rf_addr);
    end
    tick();
    tick();
    n_cmp++;
    if (b.rsp_valid !== 1'b1 || b.rsp_a !== 16'h0F0F ||
        b.rsp_b !== 16'h1000) begin
      n_bad++;
      $display("FAIL b2b_rsp got v=%b a=%h b=%h want 1 0f0f 1000",
               b.rsp_valid, b.rsp_a, b.rsp_b);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    issue(1'b0, 16'd3, 16'd7, 16'h0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({b.rf_en, b.rsp_valid, b.req_ready} !== 3'b000 ||
        b.rf_addr !== 16'd0) begin
      n_bad++;
      $display("FAIL mid_rst got en/v/rdy=%b a=%h want 000 0",
               {b.rf_en, b.rsp_valid, b.req_ready}, b.rf_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({b.rsp_valid, b.req_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL mid_rst_idle got v/rdy=%b want 01",
               {b.rsp_valid, b.req_ready});
    end
    issue(1'b0, 16'd7, 16'd3, 16'h0);
    tick();
    n_cmp++;
    if (b.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst_early got v=%b want 0", b.rsp_valid);
    end
    tick();
    n_cmp++;
    if (b.rsp_valid !== 1'b1 || b.rsp_a !== 16'h1234 ||
        b.rsp_b !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL mid_rst_rsp got v=%b a=%h b=%h want 1 1234 beef",
               b.rsp_valid, b.rsp_a, b.rsp_b);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 + 16'(i);
    b.req_valid  = 1'b0;
    b.req_wr     = 1'b0;
    b.req_addr_a = '0;
    b.req_addr_b = '0;
    b.req_data   = '0;
    b.rsp_ready  = 1'b1;
    test_reset();
    test_write_read();
    test_backpressure();
    test_same_addr();
    test_back_to_back();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
